spi_cfg_controller: RTL and testbench



---
 rtl/spi_cfg_controller.sv | 260 ++++++++++++++++++++++++++
 tb/tb_spi_cfg_controller.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_controller
// Purpose  : Queues {addr, data} register-write commands in a small FIFO and
//            serialises each one as a 16-bit mode-0, MSB-first, write-only SPI
//            frame {1'b1, addr, data}, followed by a chip-select gap.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            cmd_valid/cmd_ready - command handshake (ready == !fifo full)
//            cmd_addr, cmd_data  - 7-bit register address, 8-bit write data
//            sclk, ncs, copi     - registered SPI outputs
//            done                - one-cycle pulse per completed frame
//            busy                - frame in progress or commands pending
//            fifo_level          - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module spi_cfg_controller #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [6:0]                  cmd_addr,
    input  logic [7:0]                  cmd_data,
    output logic                        sclk,
    output logic                        ncs,
    output logic                        copi,
    output logic                        done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_DIV_W   = $clog2(c_CNT_MAX);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_GAP_LAST = c_DIV_W'(CS_GAP - 1);
    localparam logic [c_AW:0]      c_FULL_LVL = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_LOW  = 3'd1;
    localparam logic [2:0] c_S_HIGH = 3'd2;
    localparam logic [2:0] c_S_HOLD = 3'd3;
    localparam logic [2:0] c_S_GAP  = 3'd4;

    // FIFO storage and pointers
    logic [14:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;

    // Sequencer state
    logic [2:0]         r_state;
    logic               r_loaded;   // shift register holds a popped frame not yet started
    logic [c_DIV_W-1:0] r_div;
    logic [4:0]         r_bitcnt;
    logic [15:0]        r_shreg;
    logic               r_sclk;
    logic               r_ncs;
    logic               r_copi;
    logic               r_done;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [14:0]        w_rd_word;

    logic [2:0]         w_state_nxt;
    logic               w_loaded_nxt;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic [4:0]         w_bitcnt_nxt;
    logic [15:0]        w_shreg_nxt;
    logic               w_sclk_nxt;
    logic               w_ncs_nxt;
    logic               w_copi_nxt;
    logic               w_done_nxt;

    assign w_full     = (r_count == c_FULL_LVL);
    assign w_empty    = (r_count == '0);
    assign w_push     = cmd_valid && !w_full;
    assign w_rd_word  = r_mem[r_rd_ptr];

    assign cmd_ready  = !w_full;
    assign fifo_level = r_count;
    assign busy       = (r_state != c_S_IDLE) || r_loaded || !w_empty;
    assign sclk       = r_sclk;
    assign ncs        = r_ncs;
    assign copi       = r_copi;
    assign done       = r_done;

    // FIFO data array carries no reset: the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_addr, cmd_data};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= c_S_IDLE;
            r_loaded <= 1'b0;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_sclk   <= 1'b0;
            r_ncs    <= 1'b1;
            r_copi   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_state  <= w_state_nxt;
            r_loaded <= w_loaded_nxt;
            r_div    <= w_div_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_sclk   <= w_sclk_nxt;
            r_ncs    <= w_ncs_nxt;
            r_copi   <= w_copi_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state logic. A frame is popped either from IDLE or on the last GAP
    // cycle, so back-to-back frames lose no extra IDLE cycle between them.
    always_comb begin
        w_state_nxt  = r_state;
        w_loaded_nxt = r_loaded;
        w_div_nxt    = r_div;
        w_pop        = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (r_loaded) begin
                    w_state_nxt  = c_S_LOW;
                    w_loaded_nxt = 1'b0;
                    w_div_nxt    = '0;
                end else if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_loaded_nxt = 1'b1;
                end
            end
            c_S_LOW: begin
                if (r_div == c_DIV_LAST) begin
                    w_state_nxt = c_S_HIGH;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt   = r_div + 1'b1;
                end
            end
            c_S_HIGH: begin
                if (r_div == c_DIV_LAST) begin
                    w_state_nxt = (r_bitcnt == 5'd15) ? c_S_HOLD : c_S_LOW;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt   = r_div + 1'b1;
                end
            end
            c_S_HOLD: begin
                if (r_div == c_DIV_LAST) begin
                    w_state_nxt = c_S_GAP;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt   = r_div + 1'b1;
                end
            end
            c_S_GAP: begin
                if (r_div == c_GAP_LAST) begin
                    w_state_nxt = c_S_IDLE;
                    w_div_nxt   = '0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_loaded_nxt = 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = c_S_IDLE;
                w_loaded_nxt = 1'b0;
                w_div_nxt    = '0;
            end
        endcase
    end

    // Output and datapath logic; every SPI pin is taken from a flop.
    always_comb begin
        w_sclk_nxt   = r_sclk;
        w_ncs_nxt    = r_ncs;
        w_copi_nxt   = r_copi;
        w_done_nxt   = 1'b0;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        if (w_pop) begin
            w_shreg_nxt  = {1'b1, w_rd_word};
            w_bitcnt_nxt = '0;
        end
        case (r_state)
            c_S_IDLE: begin
                if (r_loaded) begin
                    w_ncs_nxt  = 1'b0;
                    w_sclk_nxt = 1'b0;
                    w_copi_nxt = r_shreg[15];
                end
            end
            c_S_LOW: begin
                if (r_div == c_DIV_LAST) begin
                    w_sclk_nxt = 1'b1;
                end
            end
            c_S_HIGH: begin
                // copi only moves on the falling sclk edge, a full half-period
                // before the next rising edge.
                if (r_div == c_DIV_LAST) begin
                    w_sclk_nxt   = 1'b0;
                    w_bitcnt_nxt = r_bitcnt + 5'd1;
                    if (r_bitcnt == 5'd15) begin
                        w_copi_nxt = 1'b0;
                    end else begin
                        w_shreg_nxt = {r_shreg[14:0], 1'b0};
                        w_copi_nxt  = r_shreg[14];
                    end
                end
            end
            c_S_HOLD: begin
                if (r_div == c_DIV_LAST) begin
                    w_ncs_nxt  = 1'b1;
                    w_done_nxt = 1'b1;
                end
            end
            c_S_GAP: begin
                w_ncs_nxt = 1'b1;
            end
            default: begin
                w_sclk_nxt = 1'b0;
                w_ncs_nxt  = 1'b1;
                w_copi_nxt = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cfg_controller
// Purpose  : Self-checking bench for spi_cfg_controller. Two instances share
//            clk/rst_n: one with default settings, one with the minimum
//            CLK_DIV/CS_GAP. A bus monitor decodes frames and drives a model
//            of the SPI config peripheral (registers 0x00..0x04).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_controller;

    localparam int c_D0 = 4;
    localparam int c_G0 = 4;
    localparam int c_D1 = 2;
    localparam int c_G1 = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_ready;
    logic [13:0] cmd_addr;
    logic [15:0] cmd_data;
    logic [1:0]  sclk_v;
    logic [1:0]  ncs_v;
    logic [1:0]  copi_v;
    logic [1:0]  done_v;
    logic [1:0]  busy_v;
    logic [2:0]  lvl0;
    logic [2:0]  lvl1;

    always #5 clk = ~clk;

    spi_cfg_controller #(.CLK_DIV(c_D0), .FIFO_DEPTH(4), .CS_GAP(c_G0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid[0]),
        .cmd_ready  (cmd_ready[0]),
        .cmd_addr   (cmd_addr[6:0]),
        .cmd_data   (cmd_data[7:0]),
        .sclk       (sclk_v[0]),
        .ncs        (ncs_v[0]),
        .copi       (copi_v[0]),
        .done       (done_v[0]),
        .busy       (busy_v[0]),
        .fifo_level (lvl0)
    );

    spi_cfg_controller #(.CLK_DIV(c_D1), .FIFO_DEPTH(4), .CS_GAP(c_G1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid[1]),
        .cmd_ready  (cmd_ready[1]),
        .cmd_addr   (cmd_addr[13:7]),
        .cmd_data   (cmd_data[15:8]),
        .sclk       (sclk_v[1]),
        .ncs        (ncs_v[1]),
        .copi       (copi_v[1]),
        .done       (done_v[1]),
        .busy       (busy_v[1]),
        .fifo_level (lvl1)
    );

    // ---------------------------------------------------------------- checks
    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endfunction

    // --------------------------------------------------------------- monitor
    typedef struct {
        int          dut;
        logic [15:0] bits;
        int          rises;
        int          low;
        int          fall;
        bit          done_ok;
        bit          copi_ok;
    } frame_rec_t;

    frame_rec_t  mon_q[$];
    frame_rec_t  mrec;
    int          cyc = 0;
    logic [1:0]  p_ncs;
    logic [1:0]  p_sclk;
    logic [1:0]  p_copi;
    logic [15:0] m_bits [2];
    int          m_rises [2];
    int          m_fall [2];
    int          m_chg [2];
    bit          m_copi_ok [2];
    int          done_cnt [2];
    int          wr_cnt [2];
    logic [7:0]  periph [2][5];
    int          mdv;
    int          midx;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        p_ncs  = 2'b11;
        p_sclk = 2'b00;
        p_copi = 2'b00;
        for (int d = 0; d < 2; d++) begin
            m_bits[d]    = '0;
            m_rises[d]   = 0;
            m_fall[d]    = 0;
            m_chg[d]     = 0;
            m_copi_ok[d] = 1'b1;
            done_cnt[d]  = 0;
            wr_cnt[d]    = 0;
            for (int r = 0; r < 5; r++) periph[d][r] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                mdv = (d == 0) ? c_D0 : c_D1;
                if (!rst_n) begin
                    m_rises[d] = 0;
                    p_ncs[d]   = 1'b1;
                    p_sclk[d]  = 1'b0;
                    p_copi[d]  = 1'b0;
                end else begin
                    if (done_v[d]) done_cnt[d]++;
                    if (copi_v[d] !== p_copi[d]) begin
                        if (sclk_v[d]) m_copi_ok[d] = 1'b0;
                        m_chg[d] = cyc;
                    end
                    if (p_ncs[d] && !ncs_v[d]) begin
                        m_fall[d]    = cyc;
                        m_rises[d]   = 0;
                        m_bits[d]    = '0;
                        m_copi_ok[d] = 1'b1;
                    end
                    if (!ncs_v[d] && sclk_v[d] && !p_sclk[d]) begin
                        m_bits[d] = {m_bits[d][14:0], copi_v[d]};
                        m_rises[d]++;
                        if (cyc - m_chg[d] < mdv) m_copi_ok[d] = 1'b0;
                    end
                    if (!p_ncs[d] && ncs_v[d]) begin
                        mrec.dut     = d;
                        mrec.bits    = m_bits[d];
                        mrec.rises   = m_rises[d];
                        mrec.low     = cyc - m_fall[d];
                        mrec.fall    = m_fall[d];
                        mrec.done_ok = (done_v[d] === 1'b1);
                        mrec.copi_ok = m_copi_ok[d];
                        mon_q.push_back(mrec);
                        // peripheral: write bit set, complete frame, mapped address
                        midx = int'(m_bits[d][14:8]);
                        if (m_rises[d] == 16 && m_bits[d][15] && midx < 5) begin
                            periph[d][midx] = m_bits[d][7:0];
                            wr_cnt[d]++;
                        end
                    end
                    p_ncs[d]  = ncs_v[d];
                    p_sclk[d] = sclk_v[d];
                    p_copi[d] = copi_v[d];
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic push(input int d, input logic [6:0] a, input logic [7:0] v,
                        output bit ok, output int waited);
        int n;
        @(negedge clk);
        cmd_valid[d]       = 1'b1;
        cmd_addr[d*7 +: 7] = a;
        cmd_data[d*8 +: 8] = v;
        n = 0;
        while (!cmd_ready[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok     = cmd_ready[d];
        waited = n;
        @(posedge clk);
        #1 cmd_valid[d] = 1'b0;
    endtask

    task automatic expect_frame(input int d, input logic [15:0] f, input string tag,
                                output int fall);
        int n;
        frame_rec_t r;
        n    = 0;
        fall = 0;
        while (mon_q.size() == 0 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (mon_q.size() == 0) begin
            chk({tag, " frame_timeout"}, 0, 1);
            return;
        end
        r = mon_q.pop_front();
        fall = r.fall;
        chk({tag, " dut"}, r.dut, d);
        chk({tag, " frame"}, r.bits, f);
        chk({tag, " sclk_rises"}, r.rises, 16);
        chk({tag, " ncs_low_cycles"}, r.low, 33 * ((d == 0) ? c_D0 : c_D1));
        chk({tag, " done_at_ncs_rise"}, r.done_ok, 1);
        chk({tag, " copi_timing"}, r.copi_ok, 1);
    endtask

    // ------------------------------------------------------------------ test
    typedef struct {
        logic [6:0]  a;
        logic [7:0]  v;
        logic [15:0] f;
        int          wr;
    } vec_t;

    vec_t        vt [6];
    logic [7:0]  exp_regs [5];
    logic [7:0]  snap [5];
    logic [7:0]  mdl [5];
    logic [15:0] exp_q[$];
    bit          ok;
    int          w;
    int          fall;
    int          prev_fall;
    int          dc;
    int          wc;
    int          n;
    int          gap;
    logic [6:0]  ra;
    logic [7:0]  rv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vt[0] = '{7'h04, 8'h80, 16'h8480, 1};
        vt[1] = '{7'h05, 8'h12, 16'h8512, 0};
        vt[2] = '{7'h00, 8'hA5, 16'h80A5, 1};
        vt[3] = '{7'h01, 8'h5A, 16'h815A, 1};
        vt[4] = '{7'h02, 8'hFF, 16'h82FF, 1};
        vt[5] = '{7'h03, 8'h0F, 16'h830F, 1};
        exp_regs = '{8'hA5, 8'h5A, 8'hFF, 8'h0F, 8'h80};

        rst_n     = 1'b0;
        cmd_valid = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst sclk", sclk_v, 2'b00);
        chk("rst ncs", ncs_v, 2'b11);
        chk("rst copi", copi_v, 2'b00);
        chk("rst done", done_v, 2'b00);
        chk("rst busy", busy_v, 2'b00);
        chk("rst fifo_level0", lvl0, 0);
        chk("rst fifo_level1", lvl1, 0);
        chk("rst cmd_ready", cmd_ready, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle ncs", ncs_v, 2'b11);
        chk("idle busy", busy_v, 2'b00);

        // Table: one command at a time on the default instance.
        for (int i = 0; i < 6; i++) begin
            dc = done_cnt[0];
            wc = wr_cnt[0];
            push(0, vt[i].a, vt[i].v, ok, w);
            chk($sformatf("vec%0d accepted", i), ok, 1);
            expect_frame(0, vt[i].f, $sformatf("vec%0d", i), fall);
            repeat (c_G0 - 1) @(negedge clk);
            #1 chk($sformatf("vec%0d busy_in_gap", i), busy_v[0], 1);
            @(negedge clk);
            #1 chk($sformatf("vec%0d busy_after_gap", i), busy_v[0], 0);
            chk($sformatf("vec%0d done_pulses", i), done_cnt[0] - dc, 1);
            chk($sformatf("vec%0d periph_writes", i), wr_cnt[0] - wc, vt[i].wr);
        end
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("periph0 reg%0d", r), periph[0][r], exp_regs[r]);
        end

        // Six back-to-back commands into a 4-deep FIFO (unmapped addresses).
        for (int i = 0; i < 5; i++) begin
            push(0, 7'(7'h10 + i), 8'(8'h30 + i), ok, w);
            chk($sformatf("burst%0d immediate", i), w, 0);
        end
        chk("burst full ready", cmd_ready[0], 0);
        chk("burst full level", lvl0, 4);
        push(0, 7'h15, 8'h35, ok, w);
        chk("burst6 accepted", ok, 1);
        chk("burst6 had_to_wait", (w > 0), 1);
        for (int i = 0; i < 6; i++) begin
            expect_frame(0, {1'b1, 7'(7'h10 + i), 8'(8'h30 + i)}, $sformatf("burst%0d", i), fall);
            if (i > 0) chk($sformatf("burst%0d ncs_fall_spacing", i), fall - prev_fall, 33 * c_D0 + c_G0 + 1);
            prev_fall = fall;
        end

        // Reset in the middle of a frame with two more commands queued.
        n = 0;
        while (busy_v[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset idle", busy_v[0], 0);
        for (int r = 0; r < 5; r++) snap[r] = periph[0][r];
        push(0, 7'h00, 8'h11, ok, w);
        push(0, 7'h01, 8'h22, ok, w);
        push(0, 7'h02, 8'h33, ok, w);
        dc = done_cnt[0];
        n  = 0;
        while (!(ncs_v[0] == 1'b0 && m_rises[0] == 7) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("midreset reached_7_rises", m_rises[0], 7);
        chk("midreset queued", lvl0, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset ncs", ncs_v[0], 1);
        chk("midreset sclk", sclk_v[0], 0);
        chk("midreset fifo_level", lvl0, 0);
        chk("midreset done", done_v[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset no_done", done_cnt[0] - dc, 0);
        chk("midreset no_frame", mon_q.size(), 0);
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("midreset reg%0d", r), periph[0][r], snap[r]);
        end
        push(0, 7'h03, 8'hC3, ok, w);
        expect_frame(0, 16'h83C3, "post_reset", fall);
        repeat (c_G0 + 5) @(negedge clk);
        #1;
        chk("post_reset idle", busy_v[0], 0);
        chk("post_reset queue_lost", mon_q.size(), 0);
        chk("post_reset reg3", periph[0][3], 8'hC3);

        // Minimum settings instance: three queued writes.
        push(1, 7'h00, 8'h3C, ok, w);
        push(1, 7'h02, 8'h99, ok, w);
        push(1, 7'h04, 8'h01, ok, w);
        expect_frame(1, 16'h803C, "min0", prev_fall);
        expect_frame(1, 16'h8299, "min1", fall);
        chk("min1 spacing", fall - prev_fall, 33 * c_D1 + c_G1 + 1);
        prev_fall = fall;
        expect_frame(1, 16'h8401, "min2", fall);
        chk("min2 spacing", fall - prev_fall, 33 * c_D1 + c_G1 + 1);
        chk("min reg0", periph[1][0], 8'h3C);
        chk("min reg2", periph[1][2], 8'h99);
        chk("min reg4", periph[1][4], 8'h01);

        // Randomised traffic against the command-level model.
        mdl = '{8'hA5, 8'h5A, 8'hFF, 8'hC3, 8'h80};
        for (int i = 0; i < 12; i++) begin
            ra = 7'($urandom_range(0, 9));
            rv = 8'($urandom_range(0, 255));
            exp_q.push_back({1'b1, ra, rv});
            if (ra < 7'd5) mdl[ra] = rv;
            push(0, ra, rv, ok, w);
            chk($sformatf("rand%0d accepted", i), ok, 1);
            gap = $urandom_range(0, 3);
            if (gap == 3) gap = $urandom_range(20, 200);
            repeat (gap) @(negedge clk);
        end
        for (int i = 0; i < 12; i++) begin
            expect_frame(0, exp_q.pop_front(), $sformatf("rand%0d", i), fall);
        end
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("rand reg%0d", r), periph[0][r], mdl[r]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
